// File: rtl/ife_pkg.sv
// Shared constants, state encoding and operation selects for the IFE host port.
package ife_pkg;
  localparam int AW    = 14;
  localparam int DW    = 8;
  localparam int DEPTH = 16384;

  typedef enum logic [1:0] {LOAD, ARM, RUN, DRAIN} state_t;

  localparam logic [1:0] SEL_OP0     = 2'd0;
  localparam logic [1:0] SEL_OP1     = 2'd1;
  localparam logic [1:0] SEL_MAXPOOL = 2'd2;
  localparam logic [1:0] SEL_OP3     = 2'd3;
endpackage

// File: rtl/ife_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port with read enable.
module ife_sdp_ram #(
  parameter int AW = 14,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // rdata holds while re is low, so the port doubles as a one-entry buffer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/ife_host_port.sv
// Host-side responder for one IFE: image load, ready/busy handshake,
// image and result memory service, and result drain stream.
module ife_host_port
  import ife_pkg::*;
#(
  parameter int AW    = ife_pkg::AW,
  parameter int DW    = ife_pkg::DW,
  parameter int DEPTH = ife_pkg::DEPTH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          s_valid,
  input  logic [DW-1:0] s_data,
  output logic          s_ready,
  input  logic [1:0]    cfg_sel,
  output logic [1:0]    sel,
  output logic          ready,
  input  logic          busy,
  input  logic [AW-1:0] iaddr,
  output logic [DW-1:0] idata,
  input  logic [AW-1:0] addr,
  input  logic          wen,
  input  logic [DW-1:0] data_wr,
  output logic [DW-1:0] data_rd,
  output logic          m_valid,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  input  logic          m_ready,
  output logic          done,
  output logic [AW:0]   wr_cnt
);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
  localparam logic [AW:0]   CNT_MAX = (AW + 1)'(DEPTH);

  state_t        state;
  logic [AW-1:0] ptr, drain_ptr, res_raddr;
  logic          drain_done, q_valid, q_last, res_run_q;
  logic [DW-1:0] data_rd_hold, img_dout, res_dout;
  logic          load_acc, out_free, drain_issue, img_re, res_we, res_re;

  assign load_acc    = (state == LOAD) && s_valid && s_ready;
  assign out_free    = !m_valid || m_ready;
  assign drain_issue = (state == DRAIN) && !drain_done && (!q_valid || out_free);
  assign img_re      = (state == RUN);
  assign res_we      = (state == RUN) && wen;
  assign res_re      = ((state == RUN) && !wen) || drain_issue;
  assign res_raddr   = (state == DRAIN) ? drain_ptr : addr;

  assign idata = img_dout;
  // The result read port is shared with the drain; data_rd keeps the last RUN read
  assign data_rd = res_run_q ? res_dout : data_rd_hold;

  ife_sdp_ram #(.AW(AW), .DW(DW)) u_img (
    .clk(clk), .reset(reset), .we(load_acc), .waddr(ptr), .wdata(s_data),
    .re(img_re), .raddr(iaddr), .rdata(img_dout)
  );

  ife_sdp_ram #(.AW(AW), .DW(DW)) u_res (
    .clk(clk), .reset(reset), .we(res_we), .waddr(addr), .wdata(data_wr),
    .re(res_re), .raddr(res_raddr), .rdata(res_dout)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= LOAD;
      s_ready      <= 1'b1;
      ready        <= 1'b0;
      m_valid      <= 1'b0;
      m_last       <= 1'b0;
      m_data       <= '0;
      done         <= 1'b0;
      sel          <= '0;
      wr_cnt       <= '0;
      ptr          <= '0;
      drain_ptr    <= '0;
      drain_done   <= 1'b0;
      q_valid      <= 1'b0;
      q_last       <= 1'b0;
      res_run_q    <= 1'b0;
      data_rd_hold <= '0;
    end else begin
      done <= 1'b0;
      if (res_run_q) data_rd_hold <= res_dout;
      if ((state == RUN) && !wen) res_run_q <= 1'b1;
      else if (drain_issue) res_run_q <= 1'b0;

      case (state)
        LOAD: begin
          if (load_acc) begin
            if (ptr == '0) begin
              sel    <= cfg_sel;
              wr_cnt <= '0;
            end
            if (ptr == LAST) begin
              ptr     <= '0;
              s_ready <= 1'b0;
              ready   <= 1'b1;
              state   <= ARM;
            end else begin
              ptr <= ptr + 1'b1;
            end
          end
        end
        ARM: begin
          if (busy) begin
            ready <= 1'b0;
            state <= RUN;
          end
        end
        RUN: begin
          if (wen && (wr_cnt != CNT_MAX)) wr_cnt <= wr_cnt + 1'b1;
          if (!busy) begin
            state      <= DRAIN;
            drain_ptr  <= '0;
            drain_done <= 1'b0;
            q_valid    <= 1'b0;
          end
        end
        DRAIN: begin
          if (drain_issue) begin
            drain_ptr  <= drain_ptr + 1'b1;
            drain_done <= (drain_ptr == LAST);
            q_last     <= (drain_ptr == LAST);
            q_valid    <= 1'b1;
          end else if (q_valid && out_free) begin
            q_valid <= 1'b0;
          end
          // Output register refills from the read-ahead whenever it is empty or being taken
          if (q_valid && out_free) begin
            m_valid <= 1'b1;
            m_data  <= res_dout;
            m_last  <= q_last;
          end else if (m_valid && m_ready) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
          end
          if (m_valid && m_ready && m_last) begin
            done    <= 1'b1;
            s_ready <= 1'b1;
            state   <= LOAD;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_ife_host_port.sv
// Scoreboard bench for ife_host_port: load, handshake, memory service, reset, drain.
module tb_ife_host_port;
  localparam int AW = 14, DW = 8, DEPTH = 16384;

  logic          clk = 1'b0, reset = 1'b0;
  logic          s_valid = 1'b0, s_ready;
  logic [DW-1:0] s_data = '0;
  logic [1:0]    cfg_sel = '0, sel;
  logic          ready, busy = 1'b0;
  logic [AW-1:0] iaddr = '0, addr = '0;
  logic [DW-1:0] idata, data_rd, data_wr = '0, m_data;
  logic          wen = 1'b0, m_valid, m_last, m_ready = 1'b0, done;
  logic [AW:0]   wr_cnt;

  int checks = 0, errors = 0;
  logic [DW-1:0] res_model [DEPTH];
  logic [DW-1:0] exp_q [$];

  ife_host_port dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .cfg_sel(cfg_sel), .sel(sel), .ready(ready), .busy(busy), .iaddr(iaddr), .idata(idata),
    .addr(addr), .wen(wen), .data_wr(data_wr), .data_rd(data_rd), .m_valid(m_valid),
    .m_data(m_data), .m_last(m_last), .m_ready(m_ready), .done(done), .wr_cnt(wr_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    step();
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready got %b exp 1", s_ready); end
    checks++; if ({ready, m_valid, m_last, done} !== 4'b0) begin errors++; $display("FAIL reset_flags got %b exp 0000", {ready, m_valid, m_last, done}); end
    checks++; if ({idata, data_rd, m_data} !== 24'h0) begin errors++; $display("FAIL reset_data got %h exp 000000", {idata, data_rd, m_data}); end
    checks++; if ({sel, wr_cnt} !== 17'h0) begin errors++; $display("FAIL reset_sel_cnt got %h exp 0", {sel, wr_cnt}); end
    $display("reset: s_ready=%b ready=%b wr_cnt=%0d", s_ready, ready, wr_cnt);
  endtask

  // Full ramp load; optional idle write pulses and an early busy (both must be ignored)
  task automatic load_image(input logic [1:0] sv, input bit busy_early, input bit idle_wen);
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL load_start_s_ready got %b exp 1", s_ready); end
    for (int i = 0; i < DEPTH; i++) begin
      s_valid = 1'b1;
      s_data  = i[7:0];
      cfg_sel = (i == 0) ? sv : ~sv;
      if (idle_wen) begin wen = i[0]; addr = 14'h0100; data_wr = 8'h77; end
      if (busy_early && i >= DEPTH - 10) busy = 1'b1;
      step();
    end
    s_valid = 1'b0;
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL load_end_s_ready got %b exp 0", s_ready); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL load_end_ready got %b exp 1", ready); end
    checks++; if (sel !== sv) begin errors++; $display("FAIL load_sel got %0d exp %0d", sel, sv); end
    checks++; if (wr_cnt !== '0) begin errors++; $display("FAIL load_wr_cnt got %0d exp 0", wr_cnt); end
    $display("load: %0d bytes, ready=%b sel=%0d", DEPTH, ready, sel);
  endtask

  task automatic test_handshake();
    busy = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL arm_ready got %b exp 1", ready); end
    end
    busy = 1'b1;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL busy_rise_ready got %b exp 1", ready); end
    step();
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL run_ready got %b exp 0", ready); end
    checks++; if (sel !== 2'd2) begin errors++; $display("FAIL run_sel got %0d exp 2", sel); end
    $display("handshake: ready=%b sel=%0d", ready, sel);
  endtask

  task automatic test_image_read();
    logic [AW-1:0] list [6];
    logic [DW-1:0] e;
    list = '{14'h0005, 14'h3FFF, 14'h1234, 14'h0000, 14'h2A7C, 14'h00FF};
    for (int k = 0; k < 6; k++) begin
      iaddr = list[k];
      exp_q.push_back(list[k][7:0]);
      step();
      e = exp_q.pop_front();
      checks++; if (idata !== e) begin errors++; $display("FAIL img_read addr=%h got %h exp %h", list[k], idata, e); end
      $display("img read: iaddr=%h idata=%h", list[k], idata);
    end
  endtask

  task automatic test_write_read();
    logic [DW-1:0] e;
    wen = 1'b1; addr = 14'h0100; data_wr = 8'hA5; res_model[14'h0100] = 8'hA5;
    step();
    checks++; if (wr_cnt !== 15'd1) begin errors++; $display("FAIL wr_cnt_one got %0d exp 1", wr_cnt); end
    wen = 1'b0; exp_q.push_back(res_model[14'h0100]);
    step();
    e = exp_q.pop_front();
    checks++; if (data_rd !== e) begin errors++; $display("FAIL wr_rd got %h exp %h", data_rd, e); end
    $display("write/read: addr=0100 data_rd=%h wr_cnt=%0d", data_rd, wr_cnt);
  endtask

  task automatic test_reset_midrun();
    for (int k = 0; k < 100; k++) begin
      wen = 1'b1; addr = 14'(14'h0200 + k); data_wr = 8'(k * 3 + 1);
      res_model[addr] = data_wr;
      step();
    end
    wen = 1'b0;
    checks++; if (wr_cnt !== 15'd101) begin errors++; $display("FAIL midrun_wr_cnt got %0d exp 101", wr_cnt); end
    reset = 1'b0;
    #2;
    checks++; if ({ready, m_valid} !== 2'b00) begin errors++; $display("FAIL midrun_rst_flags got %b exp 00", {ready, m_valid}); end
    checks++; if (wr_cnt !== '0) begin errors++; $display("FAIL midrun_rst_wr_cnt got %0d exp 0", wr_cnt); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL midrun_rst_s_ready got %b exp 1", s_ready); end
    checks++; if ({idata, data_rd, sel} !== 18'h0) begin errors++; $display("FAIL midrun_rst_data got %h exp 0", {idata, data_rd, sel}); end
    busy = 1'b0;
    step(); step();
    reset = 1'b1;
    step();
    $display("reset mid-run: s_ready=%b ready=%b wr_cnt=%0d", s_ready, ready, wr_cnt);
  endtask

  // Second run: busy already high at ARM entry, idle writes must not land
  task automatic test_idle_writes();
    logic [DW-1:0] e;
    load_image(2'd1, 1'b1, 1'b1);
    step();
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL early_busy_ready got %b exp 0", ready); end
    checks++; if (wr_cnt !== '0) begin errors++; $display("FAIL idle_wr_cnt got %0d exp 0", wr_cnt); end
    wen = 1'b0;
    addr = 14'h0100; exp_q.push_back(res_model[14'h0100]); step();
    e = exp_q.pop_front();
    checks++; if (data_rd !== e) begin errors++; $display("FAIL idle_res_0100 got %h exp %h", data_rd, e); end
    addr = 14'h0200; exp_q.push_back(res_model[14'h0200]); step();
    e = exp_q.pop_front();
    checks++; if (data_rd !== e) begin errors++; $display("FAIL idle_res_0200 got %h exp %h", data_rd, e); end
    $display("idle writes: wr_cnt=%0d res[0100]=%h", wr_cnt, e);
  endtask

  task automatic test_fill_saturate();
    for (int a = 0; a < DEPTH + 3; a++) begin
      wen = 1'b1; addr = 14'(a); data_wr = 8'($urandom_range(0, 255));
      res_model[addr] = data_wr;
      step();
    end
    wen = 1'b0;
    checks++; if (wr_cnt !== 15'(DEPTH)) begin errors++; $display("FAIL wr_cnt_sat got %0d exp %0d", wr_cnt, DEPTH); end
    $display("fill: wr_cnt=%0d", wr_cnt);
  endtask

  task automatic test_drain();
    int got = 0, dones = 0, cyc = 0;
    logic prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0, e, last_rd;
    addr = 14'h0100; busy = 1'b0; last_rd = res_model[14'h0100];
    for (int a = 0; a < DEPTH; a++) exp_q.push_back(res_model[a]);
    step();
    while (got < DEPTH && cyc < 60000) begin
      m_ready = ($urandom_range(0, 3) != 0);
      if (prev_stall) begin
        checks++; if ({m_valid, m_data} !== {1'b1, prev_data}) begin errors++; $display("FAIL drain_hold got %b/%h exp 1/%h", m_valid, m_data, prev_data); end
      end
      if (m_valid && m_ready) begin
        e = exp_q.pop_front();
        checks++; if (m_data !== e) begin errors++; $display("FAIL drain_data idx=%0d got %h exp %h", got, m_data, e); end
        checks++; if (m_last !== (got == DEPTH - 1)) begin errors++; $display("FAIL drain_last idx=%0d got %b exp %b", got, m_last, got == DEPTH - 1); end
        got++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      step();
      cyc++;
      if (done) dones++;
    end
    checks++; if (got != DEPTH) begin errors++; $display("FAIL drain_timeout got %0d bytes exp %0d", got, DEPTH); end
    m_ready = 1'b0;
    repeat (3) begin step(); if (done) dones++; end
    checks++; if (dones != 1) begin errors++; $display("FAIL done_pulses got %0d exp 1", dones); end
    checks++; if ({s_ready, m_valid} !== 2'b10) begin errors++; $display("FAIL drain_end got %b exp 10", {s_ready, m_valid}); end
    checks++; if (data_rd !== last_rd) begin errors++; $display("FAIL data_rd_hold got %h exp %h", data_rd, last_rd); end
    $display("drain: %0d bytes in %0d cycles, done pulses=%0d", got, cyc, dones);
  endtask

  initial begin
    test_reset();
    load_image(2'd2, 1'b0, 1'b0);
    test_handshake();
    test_image_read();
    test_write_read();
    test_reset_midrun();
    test_idle_writes();
    test_fill_saturate();
    test_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
